// File: rtl/prio_encoder_rr.sv
// Registered N-to-index priority encoder with fixed or round-robin priority,
// multi-hot / empty flags and a valid/ack result handshake.
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         en,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic         multi,
  output logic         none
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W:0]   N_EXT = N[W:0];
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] idx_p1;
  logic [W-1:0] ptr;
  logic         vld_p1;
  logic         multi_p1;
  logic         none_p1;

  logic         take;
  logic         is_zero;
  logic         is_multi;
  logic [W-1:0] grant;
  logic [W-1:0] ptr_next;

  function automatic logic [W-1:0] pick_low(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Rotate the request vector so that ptr lands on bit 0, pick the lowest set
  // bit there, then map the rotated index back modulo N (works for any N).
  function automatic logic [W-1:0] pick_rotated(input logic [N-1:0] v,
                                                input logic [W-1:0] p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;
    dbl = {v, v} >> p;
    rot = dbl[N-1:0];
    sum = {1'b0, p} + {1'b0, pick_low(rot)};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[W-1:0];
  endfunction

  function automatic logic has_multi(input logic [N-1:0] v);
    return |(v & (v - ONE));
  endfunction

  // Stage p0: combinational selection from the raw request vector
  always_comb begin
    take     = en && (!vld_p1 || ack);
    is_zero  = (in == '0);
    is_multi = has_multi(in);
    grant    = (MODE == 1) ? pick_rotated(in, ptr) : pick_low(in);
    ptr_next = (grant == LAST) ? '0 : grant + W'(1);
  end

  // Stage p1: registered result, held while valid and not acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p1   <= '0;
      vld_p1   <= 1'b0;
      multi_p1 <= 1'b0;
      none_p1  <= 1'b0;
      ptr      <= '0;
    end else if (take) begin
      if (is_zero) begin
        idx_p1   <= '0;
        vld_p1   <= 1'b0;
        multi_p1 <= 1'b0;
        none_p1  <= 1'b1;
      end else begin
        idx_p1   <= grant;
        vld_p1   <= 1'b1;
        multi_p1 <= is_multi;
        none_p1  <= 1'b0;
        if (MODE == 1) ptr <= ptr_next;
      end
    end else if (ack && vld_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out   = idx_p1;
  assign valid = vld_p1;
  assign multi = multi_p1;
  assign none  = none_p1;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) share one stimulus bus; each step queues the hand-computed result.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, ack;
  logic [7:0] in8;
  logic [4:0] in5;

  logic [2:0] out0, out1, out2;
  logic       valid0, valid1, valid2;
  logic       multi0, multi1, multi2;
  logic       none0, none1, none2;

  prio_encoder_rr #(.N(8), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .in(in8), .en(en), .ack(ack),
    .out(out0), .valid(valid0), .multi(multi0), .none(none0)
  );

  prio_encoder_rr #(.N(8), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .in(in8), .en(en), .ack(ack),
    .out(out1), .valid(valid1), .multi(multi1), .none(none1)
  );

  prio_encoder_rr #(.N(5), .W(3), .MODE(1)) d2 (
    .clk(clk), .rst(rst), .in(in5), .en(en), .ack(ack),
    .out(out2), .valid(valid2), .multi(multi2), .none(none2)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] out;
    logic       valid;
    logic       multi;
    logic       none;
    logic [2:0] ptr;
  } exp_t;

  exp_t  q[$];
  string names[$];
  int    checks = 0;
  int    errors = 0;

  task automatic step(input string nm, input logic r, input logic e, input logic a,
                      input logic [7:0] i8, input logic [4:0] i5, input logic [1:0] sel,
                      input logic [2:0] o, input logic v, input logic m, input logic z,
                      input logic [2:0] p);
    exp_t x;
    rst = r; en = e; ack = a; in8 = i8; in5 = i5;
    x.sel = sel; x.out = o; x.valid = v; x.multi = m; x.none = z; x.ptr = p;
    q.push_back(x);
    names.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    string      nm;
    logic [8:0] act_v, exp_v;
    if (q.size() > 0) begin
      e  = q.pop_front();
      nm = names.pop_front();
      case (e.sel)
        2'd0:    act_v = {out0, valid0, multi0, none0, d0.ptr};
        2'd1:    act_v = {out1, valid1, multi1, none1, d1.ptr};
        default: act_v = {out2, valid2, multi2, none2, d2.ptr};
      endcase
      exp_v = {e.out, e.valid, e.multi, e.none, e.ptr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s dut%0d got out=%0d valid=%b multi=%b none=%b ptr=%0d, required out=%0d valid=%b multi=%b none=%b ptr=%0d",
                 nm, e.sel, act_v[8:6], act_v[5], act_v[4], act_v[3], act_v[2:0],
                 e.out, e.valid, e.multi, e.none, e.ptr);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; ack = 1'b0; in8 = '0; in5 = '0;

    // N=8 fixed priority
    step("reset0",    1, 0, 0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("onehot",  0, 1, 1, 8'(1 << i), 5'h00, 0, 3'(i), 1, 0, 0, 0);
    step("fixmulti",  0, 1, 1, 8'b1010_0100, 5'h00, 0, 2, 1, 1, 0, 0);
    step("fixmulti2", 0, 1, 1, 8'b1010_0100, 5'h00, 0, 2, 1, 1, 0, 0);
    step("load4",     0, 1, 1, 8'h10, 5'h00, 0, 4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall",   0, 1, 0, 8'h02, 5'h00, 0, 4, 1, 0, 0, 0);
    step("accept",    0, 0, 1, 8'h02, 5'h00, 0, 4, 0, 0, 0, 0);
    step("idle",      0, 0, 0, 8'h02, 5'h00, 0, 4, 0, 0, 0, 0);
    step("zero",      0, 1, 0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 0);
    step("afterzero", 0, 1, 0, 8'h40, 5'h00, 0, 6, 1, 0, 0, 0);

    // N=8 round-robin
    step("reset1",    1, 0, 0, 8'h00, 5'h00, 1, 0, 0, 0, 0, 0);
    step("rr_a",      0, 1, 1, 8'b1000_0101, 5'h00, 1, 0, 1, 1, 0, 1);
    step("rr_b",      0, 1, 1, 8'b1000_0101, 5'h00, 1, 2, 1, 1, 0, 3);
    step("rr_c",      0, 1, 1, 8'b1000_0101, 5'h00, 1, 7, 1, 1, 0, 0);
    step("rr_d",      0, 1, 1, 8'b1000_0101, 5'h00, 1, 0, 1, 1, 0, 1);
    step("rr_onehot", 0, 1, 1, 8'h08, 5'h00, 1, 3, 1, 0, 0, 4);
    step("rr_zero",   0, 1, 1, 8'h00, 5'h00, 1, 0, 0, 0, 1, 4);
    step("rr_wrap",   0, 1, 1, 8'h01, 5'h00, 1, 0, 1, 0, 0, 1);

    // N=5 round-robin with reset while a result is pending
    step("reset2",    1, 0, 0, 8'h00, 5'h00, 2, 0, 0, 0, 0, 0);
    step("n5_top",    0, 1, 1, 8'h00, 5'b10000, 2, 4, 1, 0, 0, 0);
    step("n5_multi",  0, 1, 1, 8'h00, 5'b00011, 2, 0, 1, 1, 0, 1);
    step("n5_scan",   0, 1, 1, 8'h00, 5'b10001, 2, 4, 1, 1, 0, 0);
    step("n5_rst",    1, 1, 1, 8'h00, 5'b00011, 2, 0, 0, 0, 0, 0);
    step("n5_idle",   0, 0, 0, 8'h00, 5'b00011, 2, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
